display_arbiter: RTL and testbench
==================================

# display_arbiter

Time-shares the board's 8-digit seven-segment display between two requesters: the music player's status display and the breathing-light level display. It sits between those requesters and the `digit_enable` / `segment_data` pins at the top level. The block contains:
- a three-state arbiter with a minimum hold time, so the display does not flicker between owners;
- a digit-scan prescaler;
- a registered hex-to-segment output stage.

## Interface
- `SCAN_DIV`, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥2.
- `HOLD_TICKS`, 2000: minimum ownership time, in scan ticks, before a contended switch is allowed; legal range ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `req_a` in 1: music requester wants the display (priority requester).
- `data_a` in 32: eight 4-bit hex codes. Digit `i` uses bits `[4i+3:4i]`; digit 0 is the rightmost.
- `dp_a` in 8: decimal point per digit, 1 = lit.
- `req_b`, `data_b`, `dp_b`: same as the A ports, for the light-level requester.
- `grant` out 2: one-hot owner. Bit 0 = A, bit 1 = B, 00 = none.
- `digit_enable` out 8: one-hot digit select, active-high.
- `segment_data` out 8: bits 0..6 = segments a..g, bit 7 = dp; active-high.

## Operation
- **States:** IDLE, OWN_A, OWN_B. `grant` is decoded directly from the state register.
- **IDLE:**
  - `req_a` → OWN_A.
  - else `req_b` → OWN_B.
  - A wins if both are asserted in the same cycle.
- **OWN_A:**
  - `req_a` low and `req_b` high → OWN_B immediately.
  - Both low → IDLE.
  - `req_a` high, `req_b` high, and `hold_cnt == HOLD_TICKS` → OWN_B (round-robin).
  - Otherwise stay.
- **OWN_B:** same rules as OWN_A with A and B swapped.
- **hold_cnt:**
  - Clears to 0 on every state change.
  - Increments on each scan tick while in OWN_A or OWN_B.
  - Saturates at `HOLD_TICKS`.
- **Prescaler:** `pre_cnt` runs 0..`SCAN_DIV`-1 and wraps. `tick` = (`pre_cnt == SCAN_DIV-1`).
- **Digit index:**
  - `idx` (3 bits) increments on `tick` and wraps 7 → 0.
  - It is never reset by grant changes; scanning is continuous.
- **Output stage:** on `tick`, load:
  - `digit_enable` ← `1 << idx_next`;
  - `segment_data` ← decode of the granted requester's nibble and dp bit at `idx_next`.
- **IDLE output:** `segment_data` ← 8'h00 (blank). `digit_enable` still scans.
- **Hex decode:** 0–F → standard a..g patterns. Examples: 0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F, A = 7'h77, F = 7'h71.
- **Data capture:** requester data is sampled only on `tick` cycles. Mid-slot data changes take effect at the next slot.

## Timing
- **Reset values:**
  - state = IDLE, `grant` = 00;
  - `pre_cnt` = 0, `idx` = 0, `hold_cnt` = 0;
  - `digit_enable` = 8'h00, `segment_data` = 8'h00.
- **Latency:**
  - First `digit_enable` (8'h02, `idx` 1) appears in the cycle after the first `tick`, i.e. `SCAN_DIV` cycles after `rst` falls.
  - A full 8-digit frame takes 8·`SCAN_DIV` cycles.
- **Grant latency:** `grant` updates 1 cycle after the request edge. The displayed owner changes at the next tick after that.
- **Simultaneous events:**
  - A hold expiry in the same cycle the owner drops its request follows the "owner low" rule, so B takes over immediately.
  - An owner-low cycle with the other requester also low goes to IDLE.
- **Reset mid-operation:** all registers return to reset values asynchronously. After release, the scan restarts from `idx` 0.
- **Wrap:** `hold_cnt` never overflows (saturating). `pre_cnt` width is clog2(`SCAN_DIV`).

## Structure
- **Shared package** (`display_pkg`):
  - `SEG_BLANK` = 8'h00;
  - the state encoding (IDLE/OWN_A/OWN_B);
  - the 16-entry hex → segment constant table, so `music_gen` can reuse it.
- **Sub-module** `seg_decode`: combinational, 4-bit code + dp → 8-bit segments. Instantiated once in the output path.
- **Integration:** the top level instantiates `display_arbiter` in place of the direct `music_gen` → pin connection.

## Test plan
All scenarios use `SCAN_DIV`=4 and `HOLD_TICKS`=3.

- **Reset:** hold `rst` for 5 cycles, then release → `grant`=00, `digit_enable`=00, `segment_data`=00. After the first tick (4 cycles), `digit_enable`=02 and `segment_data`=00.
- **Single requester:** `req_a`=1, `data_a`=32'h76543210, `dp_a`=01 → `grant`=01. Over one frame, digit 0 shows 8'hBF (0 with dp) and digit 1 shows 8'h06.
- **Simultaneous requests from IDLE:** `req_a`=`req_b`=1 in the same cycle → `grant`=01. After 3 ticks of ownership, `grant`=10. After 3 more ticks, `grant`=01 again.
- **Owner drop:** while OWN_A with `hold_cnt`=1, drop `req_a` with `req_b`=1 → `grant`=10 the next cycle. The display shows `data_b` from the next tick.
- **Release:** both requests drop → `grant`=00. `segment_data`=00 from the next tick, while `digit_enable` keeps scanning 01 → 02 → … → 80 → 01.
- **Async reset mid-frame:** assert `rst` at `idx`=5 in OWN_B, between clock edges → all outputs are 0 before the next edge. After release, `digit_enable`=02 after 4 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display definitions: arbiter state encoding, blank segment code and the
// hex-to-seven-segment table (bit 0 = a ... bit 6 = g, active-high).
package display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_e;

    localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex digit plus decimal point to active-high seven-segment byte.
module seg_decode
    import display_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = {dp, HEX_SEG_TABLE[code]};
    end

endmodule

// File: rtl/display_arbiter.sv
// Time-shares the 8-digit seven-segment display between requester A (priority)
// and requester B, with minimum-hold round-robin and a continuous digit scan.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned HOLD_TICKS = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [31:0] data_a,
    input  logic [7:0]  dp_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    input  logic [7:0]  dp_b,
    output logic [1:0]  grant,
    output logic [7:0]  digit_enable,
    output logic [7:0]  segment_data
);

    localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         digit_enable_q, digit_enable_d;
    logic [7:0]         segment_data_q, segment_data_d;

    logic               tick;
    logic               hold_done;
    logic [3:0]         sel_code;
    logic               sel_dp;
    logic [7:0]         dec_seg;

    assign tick      = (pre_cnt_q == PRE_LAST);
    assign hold_done = (hold_cnt_q == HOLD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner dropping its request always wins over hold expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a)      state_d = ST_OWN_A;
                else if (req_b) state_d = ST_OWN_B;
            end
            ST_OWN_A: begin
                if (!req_a && req_b)                state_d = ST_OWN_B;
                else if (!req_a && !req_b)          state_d = ST_IDLE;
                else if (req_a && req_b && hold_done) state_d = ST_OWN_B;
            end
            ST_OWN_B: begin
                if (!req_b && req_a)                state_d = ST_OWN_A;
                else if (!req_b && !req_a)          state_d = ST_IDLE;
                else if (req_b && req_a && hold_done) state_d = ST_OWN_A;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant = 2'b00;
        case (state_q)
            ST_OWN_A: grant = 2'b01;
            ST_OWN_B: grant = 2'b10;
            default:  grant = 2'b00;
        endcase
    end

    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 3'd1 : idx_q;

        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end else if (tick && (state_q != ST_IDLE) && !hold_done) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Requester data is only looked at on tick cycles, for the slot about to start.
    always_comb begin
        sel_code = 4'h0;
        sel_dp   = 1'b0;
        case (state_q)
            ST_OWN_A: begin
                sel_code = data_a[{idx_d, 2'b00} +: 4];
                sel_dp   = dp_a[idx_d];
            end
            ST_OWN_B: begin
                sel_code = data_b[{idx_d, 2'b00} +: 4];
                sel_dp   = dp_b[idx_d];
            end
            default: begin
                sel_code = 4'h0;
                sel_dp   = 1'b0;
            end
        endcase
    end

    seg_decode u_seg_decode (
        .code (sel_code),
        .dp   (sel_dp),
        .seg  (dec_seg)
    );

    always_comb begin
        digit_enable_d = digit_enable_q;
        segment_data_d = segment_data_q;
        if (tick) begin
            digit_enable_d = 8'h01 << idx_d;
            segment_data_d = (state_q == ST_IDLE) ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            idx_q          <= '0;
            digit_enable_q <= 8'h00;
            segment_data_q <= SEG_BLANK;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            idx_q          <= idx_d;
            digit_enable_q <= digit_enable_d;
            segment_data_q <= segment_data_d;
        end
    end

    assign digit_enable = digit_enable_q;
    assign segment_data = segment_data_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with SCAN_DIV=4, HOLD_TICKS=3; ticks land on
// every 4th clock edge after reset release, so digit_enable after edge 4m is 1<<(m%8).
module tb_display_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a;
    logic [31:0] data_a;
    logic [7:0]  dp_a;
    logic        req_b;
    logic [31:0] data_b;
    logic [7:0]  dp_b;
    logic [1:0]  grant;
    logic [7:0]  digit_enable;
    logic [7:0]  segment_data;

    int checks;
    int failures;

    display_arbiter #(
        .SCAN_DIV   (4),
        .HOLD_TICKS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .data_a       (data_a),
        .dp_a         (dp_a),
        .req_b        (req_b),
        .data_b       (data_b),
        .dp_b         (dp_b),
        .grant        (grant),
        .digit_enable (digit_enable),
        .segment_data (segment_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the release, with zero edges counted since.
    task automatic do_reset();
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 32'h0;
        data_b = 32'h0;
        dp_a   = 8'h00;
        dp_b   = 8'h00;
        rst    = 1'b1;
        step(5);
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL reset_grant got=%h exp=%h", grant, 2'b00);
        end
        checks++;
        if (digit_enable !== 8'h00) begin
            failures++; $display("FAIL reset_de got=%h exp=%h", digit_enable, 8'h00);
        end
        checks++;
        if (segment_data !== 8'h00) begin
            failures++; $display("FAIL reset_seg got=%h exp=%h", segment_data, 8'h00);
        end
        step(3);
        checks++;
        if (digit_enable !== 8'h00) begin
            failures++; $display("FAIL reset_de_pre_tick got=%h exp=%h", digit_enable, 8'h00);
        end
        step(1);
        checks++;
        if (digit_enable !== 8'h02) begin
            failures++; $display("FAIL reset_first_de got=%h exp=%h", digit_enable, 8'h02);
        end
        checks++;
        if (segment_data !== 8'h00) begin
            failures++; $display("FAIL reset_first_seg got=%h exp=%h", segment_data, 8'h00);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_a  = 1'b1;
        data_a = 32'h76543210;
        dp_a   = 8'h01;
        step(1);
        checks++;
        if (grant !== 2'b01) begin
            failures++; $display("FAIL single_grant got=%h exp=%h", grant, 2'b01);
        end
        step(7);   // edge 8: digit 2
        checks++;
        if (digit_enable !== 8'h04 || segment_data !== 8'h5B) begin
            failures++; $display("FAIL single_digit2 got=%h/%h exp=04/5b", digit_enable, segment_data);
        end
        step(24);  // edge 32: digit 0
        checks++;
        if (digit_enable !== 8'h01 || segment_data !== 8'hBF) begin
            failures++; $display("FAIL single_digit0 got=%h/%h exp=01/bf", digit_enable, segment_data);
        end
        step(4);   // edge 36: digit 1
        checks++;
        if (digit_enable !== 8'h02 || segment_data !== 8'h06) begin
            failures++; $display("FAIL single_digit1 got=%h/%h exp=02/06", digit_enable, segment_data);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        data_a = 32'h11111111;
        data_b = 32'h88888888;
        req_a  = 1'b1;
        req_b  = 1'b1;
        step(1);
        checks++;
        if (grant !== 2'b01) begin
            failures++; $display("FAIL simul_first got=%h exp=%h", grant, 2'b01);
        end
        step(11);  // edge 12: third tick of A ownership
        checks++;
        if (grant !== 2'b01 || segment_data !== 8'h06) begin
            failures++; $display("FAIL simul_a_hold got=%h/%h exp=01/06", grant, segment_data);
        end
        step(1);   // edge 13: hold expired, switch to B
        checks++;
        if (grant !== 2'b10) begin
            failures++; $display("FAIL simul_rr_b got=%h exp=%h", grant, 2'b10);
        end
        step(3);   // edge 16
        checks++;
        if (segment_data !== 8'h7F) begin
            failures++; $display("FAIL simul_b_seg got=%h exp=%h", segment_data, 8'h7F);
        end
        step(8);   // edge 24
        checks++;
        if (grant !== 2'b10) begin
            failures++; $display("FAIL simul_b_hold got=%h exp=%h", grant, 2'b10);
        end
        step(1);   // edge 25
        checks++;
        if (grant !== 2'b01) begin
            failures++; $display("FAIL simul_rr_a got=%h exp=%h", grant, 2'b01);
        end
    endtask

    task automatic test_owner_drop_and_release();
        do_reset();
        data_a = 32'h33333333;
        data_b = 32'hFFFFFFFF;
        req_a  = 1'b1;
        step(4);   // edge 4: tick in OWN_A, hold_cnt becomes 1
        checks++;
        if (segment_data !== 8'h4F) begin
            failures++; $display("FAIL drop_a_seg got=%h exp=%h", segment_data, 8'h4F);
        end
        step(1);
        req_a = 1'b0;
        req_b = 1'b1;
        step(1);   // edge 6
        checks++;
        if (grant !== 2'b10) begin
            failures++; $display("FAIL drop_grant got=%h exp=%h", grant, 2'b10);
        end
        step(2);   // edge 8
        checks++;
        if (segment_data !== 8'h71 || digit_enable !== 8'h04) begin
            failures++; $display("FAIL drop_b_seg got=%h/%h exp=71/04", segment_data, digit_enable);
        end
        req_b = 1'b0;
        step(1);   // edge 9
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL release_grant got=%h exp=%h", grant, 2'b00);
        end
        step(3);   // edge 12
        for (int m = 3; m <= 8; m++) begin
            checks++;
            if (digit_enable !== (8'h01 << (m % 8)) || segment_data !== 8'h00) begin
                failures++;
                $display("FAIL release_scan m=%0d got=%h/%h exp=%h/00", m, digit_enable,
                         segment_data, 8'h01 << (m % 8));
            end
            if (m < 8) step(4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        data_b = 32'h76543210;
        req_b  = 1'b1;
        step(20);  // edge 20: idx 5
        checks++;
        if (digit_enable !== 8'h20 || grant !== 2'b10) begin
            failures++; $display("FAIL areset_pre got=%h/%h exp=20/10", digit_enable, grant);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || digit_enable !== 8'h00 || segment_data !== 8'h00) begin
            failures++;
            $display("FAIL areset_async got=%h/%h/%h exp=00/00/00", grant, digit_enable, segment_data);
        end
        step(2);
        rst = 1'b0;
        step(4);
        checks++;
        if (digit_enable !== 8'h02 || segment_data !== 8'h06) begin
            failures++; $display("FAIL areset_restart got=%h/%h exp=02/06", digit_enable, segment_data);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req_a    = 1'b0;
        req_b    = 1'b0;
        data_a   = 32'h0;
        data_b   = 32'h0;
        dp_a     = 8'h00;
        dp_b     = 8'h00;
        test_reset();
        test_single();
        test_simultaneous();
        test_owner_drop_and_release();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
